// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode format for the arbitrated ALU slice.
// Codes not listed here fall through to subtract.
package alu_arbiter_pkg;

  localparam int unsigned INSTR_W = 5;
  localparam int unsigned DATA_W  = 32;

  localparam logic [INSTR_W-1:0] IADD = 5'h00;
  localparam logic [INSTR_W-1:0] IAND = 5'h01;
  localparam logic [INSTR_W-1:0] IOR  = 5'h02;
  localparam logic [INSTR_W-1:0] IXOR = 5'h03;
  localparam logic [INSTR_W-1:0] IPAS = 5'h04;
  localparam logic [INSTR_W-1:0] ILT  = 5'h05;
  localparam logic [INSTR_W-1:0] ILTU = 5'h06;
  localparam logic [INSTR_W-1:0] IGE  = 5'h07;
  localparam logic [INSTR_W-1:0] IGEU = 5'h08;
  localparam logic [INSTR_W-1:0] IEQ  = 5'h09;
  localparam logic [INSTR_W-1:0] INE  = 5'h0A;
  localparam logic [INSTR_W-1:0] ISUB = 5'h0B;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester operation bus plus single response channel for alu_arbiter.
interface alu_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [4:0]       req0_instr;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [4:0]       req1_instr;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_instr, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_instr, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_tag, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_instr, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_instr, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_tag, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU (module alu); undefined opcodes compute a - b.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [4:0]  instr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic lt_s;
  logic lt_u;

  always_comb begin
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    y    = '0;
    case (instr)
      IADD:    y = a + b;
      IAND:    y = a & b;
      IOR:     y = a | b;
      IXOR:    y = a ^ b;
      IPAS:    y = b;
      ILT:     y = {31'b0, lt_s};
      ILTU:    y = {31'b0, lt_u};
      IGE:     y = {31'b0, !lt_s};
      IGEU:    y = {31'b0, !lt_u};
      IEQ:     y = {31'b0, a == b};
      INE:     y = {31'b0, a != b};
      default: y = a - b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-way arbiter in front of a single ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_RR_EN for round-robin grant; default is fixed priority to requester 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [4:0]       op_instr_q, op_instr_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d;
  logic             op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             busy_q, busy_d;
`ifdef ALU_ARB_RR_EN
  logic             last_grant_q, last_grant_d;
`endif

  logic        grant_id;
  logic        idle;
  logic        accept;
  logic [31:0] alu_y;

  // Grant is resolved every cycle; readies only qualify it in IDLE.
  always_comb begin
    grant_id = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (bus.req0_valid && bus.req1_valid) grant_id = !last_grant_q;
    else                                  grant_id = bus.req1_valid;
`else
    grant_id = !bus.req0_valid && bus.req1_valid;
`endif
  end

  assign idle           = (state_q == ST_IDLE);
  assign bus.req0_ready = idle && bus.req0_valid && !grant_id;
  assign bus.req1_ready = idle && bus.req1_valid && grant_id;
  assign accept         = bus.req0_ready || bus.req1_ready;

  alu u_alu (
    .instr (op_instr_q),
    .a     (op_a_q),
    .b     (op_b_q),
    .y     (alu_y)
  );

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_instr_d  = op_instr_q;
    op_tag_d    = op_tag_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    busy_d      = busy_q;
`ifdef ALU_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_a_d     = grant_id ? bus.req1_a     : bus.req0_a;
          op_b_d     = grant_id ? bus.req1_b     : bus.req0_b;
          op_instr_d = grant_id ? bus.req1_instr : bus.req0_instr;
          op_tag_d   = grant_id ? bus.req1_tag   : bus.req0_tag;
          op_id_d    = grant_id;
          state_d    = ST_EXEC;
          busy_d     = 1'b1;
`ifdef ALU_ARB_RR_EN
          last_grant_d = grant_id;
`endif
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_y;
        rsp_id_d    = op_id_q;
        rsp_tag_d   = op_tag_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_instr_q  <= '0;
      op_tag_q    <= '0;
      op_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      busy_q      <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_instr_q  <= op_instr_d;
      op_tag_q    <= op_tag_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      busy_q      <= busy_d;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode vector table plus arbitration,
// backpressure and mid-operation reset sequences (ALU_ARB_RR_EN aware).
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_arbiter_if #(.TAG_W(4)) bus ();

  alu_arbiter #(.TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [4:0]  instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Inputs already presented; expects accept on the next edge, rsp_ready high.
  task automatic run_op(input string nm, input logic exp_id, input logic [31:0] exp_data,
                        input logic [3:0] exp_tag, input bit drop_valid);
    @(negedge clk);
    chk({nm, ".ready0"}, {31'b0, bus.req0_ready}, {31'b0, !exp_id});
    chk({nm, ".ready1"}, {31'b0, bus.req1_ready}, {31'b0, exp_id});
    @(posedge clk); #1;
    if (drop_valid) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_a = ~bus.req0_a;
      bus.req1_a = ~bus.req1_a;
      bus.req0_b = bus.req0_b + 32'd17;
      bus.req1_b = bus.req1_b + 32'd17;
      bus.req0_instr = ISUB;
      bus.req1_instr = ISUB;
    end
    chk({nm, ".exec_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({nm, ".exec_busy"},  {31'b0, bus.busy},      32'd1);
    @(posedge clk); #1;
    chk({nm, ".rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
    chk({nm, ".rsp_data"},  bus.rsp_data,           exp_data);
    chk({nm, ".rsp_id"},    {31'b0, bus.rsp_id},    {31'b0, exp_id});
    chk({nm, ".rsp_tag"},   {28'b0, bus.rsp_tag},   {28'b0, exp_tag});
    chk({nm, ".resp_rdy"},  {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
    @(posedge clk); #1;
    chk({nm, ".idle_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({nm, ".idle_busy"},  {31'b0, bus.busy},      32'd0);
  endtask

  task automatic set_req(input logic sel, input logic [4:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    if (sel) begin
      bus.req1_instr = instr; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
      bus.req1_valid = 1'b1;
    end else begin
      bus.req0_instr = instr; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
      bus.req0_valid = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = '{1'b0, IADD,  32'd5,        32'd7,        4'd3,  32'd12};
    vecs[1]  = '{1'b1, ILT,   32'hFFFFFFFF, 32'd1,        4'd5,  32'd1};
    vecs[2]  = '{1'b1, ILTU,  32'hFFFFFFFF, 32'd1,        4'd6,  32'd0};
    vecs[3]  = '{1'b0, IEQ,   32'd9,        32'd9,        4'd1,  32'd1};
    vecs[4]  = '{1'b0, INE,   32'd9,        32'd9,        4'd2,  32'd0};
    vecs[5]  = '{1'b1, IAND,  32'h0000F0F0, 32'h0000FF00, 4'd7,  32'h0000F000};
    vecs[6]  = '{1'b0, IXOR,  32'hA5A5A5A5, 32'hFFFF0000, 4'd8,  32'h5A5AA5A5};
    vecs[7]  = '{1'b1, IGE,   32'd1,        32'hFFFFFFFF, 4'd9,  32'd1};
    vecs[8]  = '{1'b0, IGEU,  32'd1,        32'hFFFFFFFF, 4'd10, 32'd0};
    vecs[9]  = '{1'b1, IPAS,  32'd123,      32'hDEADBEEF, 4'd11, 32'hDEADBEEF};
    vecs[10] = '{1'b0, ISUB,  32'd10,       32'd3,        4'd12, 32'd7};
    vecs[11] = '{1'b1, 5'h1F, 32'd3,        32'd5,        4'd15, 32'hFFFFFFFE};

    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_instr = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_instr = '0; bus.req1_tag = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst.busy",      {31'b0, bus.busy},      32'd0);
    chk("rst.rsp_data",  bus.rsp_data,           32'd0);
    chk("rst.rsp_id",    {31'b0, bus.rsp_id},    32'd0);
    chk("rst.rsp_tag",   {28'b0, bus.rsp_tag},   32'd0);
    rst_n = 1'b1;

    // Opcode table: one requester at a time, inputs scrambled after accept.
    for (int unsigned i = 0; i < 12; i++) begin
      set_req(vecs[i].sel, vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].tag);
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp, vecs[i].tag, 1'b1);
    end

    // Both requesters held valid from a fresh reset.
    pulse_reset();
    set_req(1'b0, IADD, 32'd1,    32'd2,    4'd1);
    set_req(1'b1, IXOR, 32'hF0,   32'hFF,   4'd2);
    run_op("arb0", 1'b0, 32'd3, 4'd1, 1'b0);
`ifdef ALU_ARB_RR_EN
    run_op("arb1", 1'b1, 32'h0F, 4'd2, 1'b0);
`else
    run_op("arb1", 1'b0, 32'd3, 4'd1, 1'b0);
`endif
    run_op("arb2", 1'b0, 32'd3, 4'd1, 1'b1);

    // Backpressure: hold rsp_ready low for 5 cycles in RESP.
    bus.rsp_ready = 1'b0;
    set_req(1'b0, IOR, 32'hA0, 32'h05, 4'd7);
    @(negedge clk);
    chk("bp.ready0", {31'b0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    set_req(1'b1, IADD, 32'd40, 32'd2, 4'd4);
    @(posedge clk); #1;
    for (int unsigned c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d.valid", c), {31'b0, bus.rsp_valid}, 32'd1);
      chk($sformatf("bp%0d.data", c),  bus.rsp_data,           32'hA5);
      chk($sformatf("bp%0d.id", c),    {31'b0, bus.rsp_id},    32'd0);
      chk($sformatf("bp%0d.tag", c),   {28'b0, bus.rsp_tag},   32'd7);
      chk($sformatf("bp%0d.rdy", c),   {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
      chk($sformatf("bp%0d.busy", c),  {31'b0, bus.busy},      32'd1);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.rel_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("bp.rel_busy",  {31'b0, bus.busy},      32'd0);
    run_op("bp.next", 1'b1, 32'd42, 4'd4, 1'b1);

    // Reset asserted while an operation is in EXEC.
    set_req(1'b1, IADD, 32'd100, 32'd200, 4'd9);
    @(negedge clk);
    chk("rx.ready1", {31'b0, bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rx.valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rx.busy",  {31'b0, bus.busy},      32'd0);
    chk("rx.data",  bus.rsp_data,           32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rx%0d.valid", c), {31'b0, bus.rsp_valid}, 32'd0);
      chk($sformatf("rx%0d.busy", c),  {31'b0, bus.busy},      32'd0);
    end
    pulse_reset();
    set_req(1'b0, IADD, 32'd20, 32'd22, 4'd5);
    run_op("rx.first", 1'b0, 32'd42, 4'd5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
